// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adder_pkg                                                        |
// | Brief   : Shared types and defaults for the multi-cycle adder/subtractor.  |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Width of a counter able to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adder_slice                                                      |
// | Brief   : Combinational CHUNK-bit ripple adder with MSB carry-in tap.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  assign cout     = w_c[CHUNK];
  // Carry into the top bit; XOR with cout gives signed overflow on the last chunk.
  assign c_msb_in = w_c[CHUNK-1];

endmodule : adder_slice
`default_nettype wire

// File: rtl/adder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adder_seq                                                        |
// | Brief   : Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock,    |
// |           valid/ready on both sides. Optional ADDER_SEQ_ACC_EN adds an     |
// |           acc_en input that feeds the previous sum back as operand A.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module adder_seq
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
`ifdef ADDER_SEQ_ACC_EN
  input  logic             acc_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("adder_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_carry_out;
  logic             r_overflow;

  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_c_msb_in;
  logic             w_last;
  logic [WIDTH-1:0] w_work_next;
  logic [WIDTH-1:0] w_a_src;

`ifdef ADDER_SEQ_ACC_EN
  assign w_a_src = acc_en ? r_sum : a;
`else
  assign w_a_src = a;
`endif

  // Operands shift right one chunk per cycle, so the slice always sees bit 0 upward.
  adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a        (r_a[CHUNK-1:0]),
    .b        (r_b[CHUNK-1:0]),
    .cin      (r_c),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb_in)
  );

  // Result chunks enter at the top; after NCHUNK shifts chunk 0 sits at the LSB.
  assign w_work_next = (r_work >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));
  assign w_last      = (r_cnt == CW'(NCHUNK - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_work      <= '0;
      r_sum       <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= w_a_src;
            r_b        <= b ^ {WIDTH{sub}};
            r_c        <= sub | carry_in;
            r_cnt      <= '0;
            r_work     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= BUSY;
          end
        end

        BUSY: begin
          r_a    <= r_a >> CHUNK;
          r_b    <= r_b >> CHUNK;
          r_c    <= w_cout;
          r_work <= w_work_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum       <= w_work_next;
            r_carry_out <= w_cout;
            r_overflow  <= w_cout ^ w_c_msb_in;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule : adder_seq
`default_nettype wire

// File: tb/tb_adder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_adder_seq                                                     |
// | Brief   : Self-checking bench for adder_seq (vectors, handshake, reset,    |
// |           random ops vs. arithmetic model; accumulate under macro).        |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_adder_seq;

  localparam int W   = 32;
  localparam int CH  = 8;
  localparam int NCH = W / CH;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
`ifdef ADDER_SEQ_ACC_EN
  logic         acc_en = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_seq #(
    .WIDTH (W),
    .CHUNK (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
`ifdef ADDER_SEQ_ACC_EN
    .acc_en    (acc_en),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  typedef struct {
    string      name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       cin;
    logic       sub;
    logic [W-1:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic, returns {overflow, carry, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    longint   sx, sy, sr, lo, hi;
    logic [W:0] u;
    logic     ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lo = -(longint'(1) << (W - 1));
    hi = (longint'(1) << (W - 1)) - 1;
    if (s) begin
      u    = {1'b0, x} - {1'b0, y};
      u[W] = (x >= y);
      sr   = sx - sy;
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      sr = sx + sy + (ci ? longint'(1) : longint'(0));
    end
    ov = (sr > hi) || (sr < lo);
    return {ov, u};
  endfunction

  // Entered and left on a falling edge. Performs one full transaction.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tcin,
                       input logic tsub, output logic [W-1:0] rs, output logic rc,
                       output logic ro);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    a        = ta;
    b        = tb_b;
    carry_in = tcin;
    sub      = tsub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(NCH));
    rs = sum;
    rc = carry_out;
    ro = overflow;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_handshake", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [W-1:0] rs, ra, rb;
    logic         rc, ro, rci, rsub;
    logic [W+1:0] exp;
    int           guard;

    vecs[0] = '{"ff_plus_1",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{"ripple_all",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{"signed_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{"sub_5_7",       32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub_7_5",       32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vecs[5] = '{"sub_min_1",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{"add_min_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[7] = '{"sub_cin_ignored", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_carry_out", 64'(carry_out), 64'(0));
    check("rst_overflow",  64'(overflow),  64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro);
      check({vecs[i].name, "_sum"}, 64'(rs), 64'(vecs[i].s));
      check({vecs[i].name, "_cout"}, 64'(rc), 64'(vecs[i].co));
      check({vecs[i].name, "_ovf"}, 64'(ro), 64'(vecs[i].ov));
    end

    // Handshake: in_valid noise and early out_ready during BUSY, long DONE stall.
    in_valid = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222; carry_in = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_in_ready", 64'(in_ready), 64'(0));
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_sum",       64'(sum),       64'(32'h3333_3333));
      check("hold_in_ready",  64'(in_ready),  64'(0));
      a = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 64'(out_valid), 64'(0));
    check("release_in_ready",  64'(in_ready),  64'(1));

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = (i % 5 == 0) ? ~ra : 32'($urandom);
      rci  = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      exp  = model(ra, rb, rci, rsub);
      do_op(ra, rb, rci, rsub, rs, rc, ro);
      check("rand_sum",  64'(rs), 64'(exp[W-1:0]));
      check("rand_cout", 64'(rc), 64'(exp[W]));
      check("rand_ovf",  64'(ro), 64'(exp[W+1]));
    end

    // Asynchronous reset two chunks into an operation, after a non-zero result.
    do_op(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro);
    check("pre_reset_sum", 64'(rs), 64'(32'h1234_5679));
    in_valid = 1'b1; a = 32'hAAAA_AAAA; b = 32'h5555_5555; carry_in = 1'b1; sub = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready",  64'(in_ready),  64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum",       64'(sum),       64'(0));
    check("midrst_carry_out", 64'(carry_out), 64'(0));
    check("midrst_overflow",  64'(overflow),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'd3, 32'd4, 1'b0, 1'b0, rs, rc, ro);
    check("post_reset_sum",  64'(rs), 64'(7));
    check("post_reset_cout", 64'(rc), 64'(0));
    check("post_reset_ovf",  64'(ro), 64'(0));

`ifdef ADDER_SEQ_ACC_EN
    acc_en = 1'b0;
    do_op(32'd10, 32'd0, 1'b0, 1'b0, rs, rc, ro);
    check("acc_step0", 64'(rs), 64'(10));
    acc_en = 1'b1;
    do_op(32'hDEAD_BEEF, 32'd5, 1'b0, 1'b0, rs, rc, ro);
    check("acc_step1", 64'(rs), 64'(15));
    do_op(32'hDEAD_BEEF, 32'd3, 1'b0, 1'b1, rs, rc, ro);
    check("acc_step2", 64'(rs), 64'(12));
    acc_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adder_seq
`default_nettype wire

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Parametrised multi-cycle adder/subtractor, the successor to the fixed 8-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using one CHUNK-bit ripple slice reused across cycles.
- Valid/ready handshake on both input and output, so it drops into datapaths that tolerate multi-cycle latency in exchange for a short carry chain.
- Reports carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- Derived: NCHUNK = WIDTH/CHUNK; CW = clog2(NCHUNK), minimum 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry into LSB chunk (add mode only)
- sub  in  1  0: a+b+carry_in; 1: a-b, computed as a+~b+1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- carry_out  out  1  carry from MSB; in sub mode 1 means no borrow
- overflow  out  1  signed overflow of the WIDTH-bit result

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; in_ready=1; out_valid=0; sum=0; carry_out=0; overflow=0; working registers and chunk counter cleared; any in-flight operation is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b^{WIDTH{sub}} and initial carry (sub ? 1 : carry_in); cnt=0; go to BUSY.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each cycle, chunk cnt = a_r[cnt*CHUNK +: CHUNK] + b_r[...] + c_r. The result is written into the working sum; the carry goes to c_r.
  - cnt increments. After the chunk with cnt=NCHUNK-1, go to DONE.
- Output registers:
  - sum, carry_out and overflow update only on the BUSY->DONE edge, so they are stable for the whole DONE period.
  - overflow = carry into MSB XOR carry out of MSB.
- Latency: operand accept at edge N gives out_valid=1 after edge N+NCHUNK.
  - Example: WIDTH=32, CHUNK=8 gives out_valid 4 cycles after accept.
  - With CHUNK=WIDTH, latency is 1.
- DONE:
  - out_valid=1, held with outputs stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept. Throughput is one operation per NCHUNK+2 cycles.
  - out_ready asserted before DONE has no effect.
- Wrap-around: sum is modulo 2^WIDTH. Carry past the MSB appears only on carry_out.
- carry_in is ignored when sub=1.
- sub and carry_in are sampled only at accept.

Optional Feature:
- Macro: ADDER_SEQ_ACC_EN.
- When defined:
  - Adds input acc_en (1 bit).
  - At accept with acc_en=1, operand A is the previous registered sum instead of port a. Results chain, e.g. running sum or difference.
  - The accumulator is the sum register and resets to 0.
- When undefined:
  - No acc_en port; A always comes from port a.
  - Behaviour is identical to acc_en=0.

Decomposition:
- Package adder_pkg holds:
  - state enum type (IDLE, BUSY, DONE);
  - default WIDTH/CHUNK localparams;
  - a clog2-based counter-width helper.
- Sub-module adder_slice: combinational CHUNK-bit ripple adder.
  - Inputs a, b, cin. Outputs s, cout, and c_msb_in (carry into the top bit, used for overflow).
  - Instantiated once and time-multiplexed across chunks.
- Elaboration-time check: WIDTH % CHUNK == 0.

Test Plan:
- WIDTH=32, CHUNK=8, add: a=0x0000_00FF, b=0x0000_0001, cin=0.
  - Expect sum=0x0000_0100, carry_out=0, overflow=0.
  - out_valid exactly 4 cycles after accept.
- Full carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0000, cin=1.
  - Expect sum=0, carry_out=1, overflow=0.
- Signed overflow and subtract:
  - a=0x7FFF_FFFF + b=1 gives sum=0x8000_0000, overflow=1.
  - sub=1 with a=5, b=7 gives sum=0xFFFF_FFFE, carry_out=0, overflow=0.
- Handshake:
  - Hold out_ready=0 for 10 cycles: out_valid and sum stay stable.
  - in_valid pulses during BUSY/DONE are ignored.
  - After out_ready, in_ready returns the next cycle.
- Reset mid-BUSY (after 2 chunks): all outputs are 0 immediately. A fresh operation 3+4=7 then completes correctly.
- ADDER_SEQ_ACC_EN defined: ops (a=10, acc_en=0, b=0), then (acc_en=1, b=5), then (acc_en=1, sub=1, b=3). Expect sums 10, 15, 12.
